// File: rtl/free_list_if.sv
// Rename/retire handshake bundle for the physical-register free list.
// Master is the rename/ROB side, slave is the free list itself.
interface free_list_if #(
  parameter int PTAG_W = 6
);
  logic              alloc_req;
  logic              alloc_valid;
  logic [PTAG_W-1:0] alloc_preg;
  logic              free_en_0;
  logic [PTAG_W-1:0] free_preg_0;
  logic              free_en_1;
  logic [PTAG_W-1:0] free_preg_1;
  logic [PTAG_W:0]   free_count;
  logic              empty;
  logic              overflow_err;

  modport master (
    output alloc_req,
    output free_en_0,
    output free_preg_0,
    output free_en_1,
    output free_preg_1,
    input  alloc_valid,
    input  alloc_preg,
    input  free_count,
    input  empty,
    input  overflow_err
  );

  modport slave (
    input  alloc_req,
    input  free_en_0,
    input  free_preg_0,
    input  free_en_1,
    input  free_preg_1,
    output alloc_valid,
    output alloc_preg,
    output free_count,
    output empty,
    output overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: show-ahead circular FIFO of tags,
// one allocation and up to two returns per cycle.
module free_list #(
  parameter int PREG_NUM = 64,
  parameter int AREG_NUM = 32,
  parameter int PTAG_W   = 6
) (
  input  logic         clk,
  input  logic         rstn,
  free_list_if.slave   fl
);
  localparam int CW = PTAG_W + 1;

  logic [PTAG_W-1:0] mem_q [PREG_NUM];
  logic [PTAG_W-1:0] head_q, head_d;
  logic [PTAG_W-1:0] tail_q, tail_d;
  logic [PTAG_W-1:0] tail_b;
  logic [PTAG_W-1:0] tag_a;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     room;
  logic              ovf_q, ovf_d;
  logic              pop, q0, q1;
  logic              acc0, acc1;
  logic              wr_a, wr_b;

  always_comb begin
    pop  = fl.alloc_req && (count_q != '0);
    q0   = fl.free_en_0 && (fl.free_preg_0 != '0);
    q1   = fl.free_en_1 && (fl.free_preg_1 != '0);
    // a same-cycle pop frees its slot for an incoming push
    room = CW'(PREG_NUM) - count_q + CW'(pop);
    acc0 = q0 && (room != '0);
    acc1 = q1 && (room > CW'(acc0));
    wr_a = acc0 || acc1;
    wr_b = acc0 && acc1;
    tag_a  = acc0 ? fl.free_preg_0 : fl.free_preg_1;
    tail_b = tail_q + PTAG_W'(1);
    tail_d = tail_q + PTAG_W'(acc0) + PTAG_W'(acc1);
    head_d = head_q + PTAG_W'(pop);
    count_d = count_q - CW'(pop) + CW'(acc0) + CW'(acc1);
    ovf_d  = ovf_q | (q0 & ~acc0) | (q1 & ~acc1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PREG_NUM; i++) begin
        mem_q[i] <= (i < PREG_NUM - AREG_NUM) ?
                    PTAG_W'(AREG_NUM + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= PTAG_W'(PREG_NUM - AREG_NUM);
      count_q <= CW'(PREG_NUM - AREG_NUM);
      ovf_q   <= 1'b0;
    end else begin
      if (wr_a) mem_q[tail_q] <= tag_a;
      if (wr_b) mem_q[tail_b] <= fl.free_preg_1;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fl.alloc_valid  = (count_q != '0);
  assign fl.alloc_preg   = fl.alloc_valid ? mem_q[head_q] : '0;
  assign fl.free_count   = count_q;
  assign fl.empty        = (count_q == '0);
  assign fl.overflow_err = ovf_q;
endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus queues expected tags,
// a monitor checks each tag the DUT hands out.
module tb_free_list;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  free_list_if #(.PTAG_W(6)) ifc();

  free_list #(
    .PREG_NUM(64),
    .AREG_NUM(32),
    .PTAG_W(6)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .fl(ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] model[$];
  logic [5:0] exp_q[$];
  logic [5:0] e_tag;
  logic       ovf_m;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic model_reset();
    model.delete();
    for (int i = 0; i < 32; i++) model.push_back(6'(32 + i));
    ovf_m = 1'b0;
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_count"}, int'(ifc.free_count), model.size());
    chk({nm, "_ovf"}, int'(ifc.overflow_err), int'(ovf_m));
    chk({nm, "_valid"}, int'(ifc.alloc_valid), int'(model.size() != 0));
    chk({nm, "_preg"}, int'(ifc.alloc_preg),
        (model.size() != 0) ? int'(model[0]) : 0);
  endtask

  // called at posedge+1; returns at the following posedge+1
  task automatic cyc(input logic a,
                     input logic e0, input logic [5:0] p0,
                     input logic e1, input logic [5:0] p1);
    ifc.alloc_req   = a;
    ifc.free_en_0   = e0;
    ifc.free_preg_0 = p0;
    ifc.free_en_1   = e1;
    ifc.free_preg_1 = p1;
    if (a && model.size() != 0) exp_q.push_back(model.pop_front());
    if (e0 && p0 != 0) begin
      if (model.size() < 64) model.push_back(p0);
      else ovf_m = 1'b1;
    end
    if (e1 && p1 != 0) begin
      if (model.size() < 64) model.push_back(p1);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    ifc.alloc_req = 1'b0;
    ifc.free_en_0 = 1'b0;
    ifc.free_en_1 = 1'b0;
    ifc.free_preg_0 = '0;
    ifc.free_preg_1 = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rstn && ifc.alloc_req && ifc.alloc_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got tag %0d expected none",
                   ifc.alloc_preg);
        end else begin
          e_tag = exp_q.pop_front();
          chk("alloc_tag", int'(ifc.alloc_preg), int'(e_tag));
        end
      end
    end
  end

  initial begin
    ifc.alloc_req = 1'b0;
    ifc.free_en_0 = 1'b0;
    ifc.free_en_1 = 1'b0;
    ifc.free_preg_0 = '0;
    ifc.free_preg_1 = '0;
    model_reset();
    #12 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_preg", int'(ifc.alloc_preg), 32);
    chk("rst_valid", int'(ifc.alloc_valid), 1);
    chk("rst_count", int'(ifc.free_count), 32);
    chk("rst_empty", int'(ifc.empty), 0);
    chk("rst_ovf", int'(ifc.overflow_err), 0);

    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("idle_preg", int'(ifc.alloc_preg), 32);
    chk("idle_count", int'(ifc.free_count), 32);

    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0);
    chk("drain_empty", int'(ifc.empty), 1);
    chk("drain_valid", int'(ifc.alloc_valid), 0);
    chk("drain_preg", int'(ifc.alloc_preg), 0);
    chk("drain_count", int'(ifc.free_count), 0);

    cyc(1, 0, 0, 0, 0);
    chk("pop_empty_count", int'(ifc.free_count), 0);
    chk("pop_empty_empty", int'(ifc.empty), 1);
    chk("pop_empty_ovf", int'(ifc.overflow_err), 0);

    cyc(1, 1, 6'd5, 1, 6'd9);
    chk("nobypass_preg", int'(ifc.alloc_preg), 5);
    chk("nobypass_count", int'(ifc.free_count), 2);
    cyc(1, 0, 0, 0, 0);
    chk("second_preg", int'(ifc.alloc_preg), 9);
    chk("second_count", int'(ifc.free_count), 1);
    cyc(1, 0, 0, 0, 0);
    chk("reempty", int'(ifc.empty), 1);

    cyc(0, 1, 6'd0, 1, 6'd7);
    chk("p0_filter_count", int'(ifc.free_count), 1);
    chk("p0_filter_preg", int'(ifc.alloc_preg), 7);
    cyc(1, 0, 0, 0, 0);

    for (int c = 0; c < 100; c++) begin
      if (c % 2 == 0)
        cyc(1, 1, 6'((c * 7) % 63 + 1), 1, 6'((c * 11 + 3) % 63 + 1));
      else
        cyc(1, 0, 0, 0, 0);
      chk_state("steady");
    end

    for (int k = 0; k < 40 && model.size() < 64; k++) begin
      if (model.size() < 63)
        cyc(0, 1, 6'(k % 63 + 1), 1, 6'((k + 20) % 63 + 1));
      else
        cyc(0, 1, 6'(k % 63 + 1), 0, 0);
    end
    chk("full_count", int'(ifc.free_count), 64);
    chk("full_ovf", int'(ifc.overflow_err), 0);

    cyc(1, 1, 6'd50, 1, 6'd51);
    chk("full_pop2_count", int'(ifc.free_count), 64);
    chk("full_pop2_ovf", int'(ifc.overflow_err), 1);
    chk_state("full_pop2");
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", int'(ifc.overflow_err), 1);

    for (int i = 0; i < 64; i++) cyc(1, 0, 0, 0, 0);
    chk("drain2_count", int'(ifc.free_count), 0);
    chk("drain2_ovf", int'(ifc.overflow_err), 1);
    chk("drain2_pending", exp_q.size(), 0);

    cyc(0, 1, 6'd12, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_preg", int'(ifc.alloc_preg), 32);
    chk("arst_count", int'(ifc.free_count), 32);
    chk("arst_valid", int'(ifc.alloc_valid), 1);
    chk("arst_empty", int'(ifc.empty), 0);
    chk("arst_ovf", int'(ifc.overflow_err), 0);
    model_reset();
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("post_rst_preg", int'(ifc.alloc_preg), 34);
    chk_state("post_rst");
    cyc(0, 0, 0, 0, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
